// File: rtl/solomon_rom_pkg.sv
// ROM map shared by the download sequencer and its region decoder.
package solomon_rom_pkg;

   localparam int unsigned NREG    = 5;
   localparam int unsigned ADDR_W  = 25;
   localparam int unsigned OFF_W   = 16;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned CKSUM_W = 16;

   // Region index naming; index i selects REG_BASE[i]/REG_END[i] and WR_SEL[i].
   typedef enum logic [2:0] {
      REG_MAIN = 3'd0,
      REG_SND  = 3'd1,
      REG_FG   = 3'd2,
      REG_BG   = 3'd3,
      REG_SPR  = 3'd4
   } region_e;

   // Byte address table, end exclusive; element 0 is the rightmost entry.
   localparam logic [NREG-1:0][ADDR_W-1:0] REG_BASE = {
      25'h20000, 25'h18000, 25'h10000, 25'h0C000, 25'h00000
   };
   localparam logic [NREG-1:0][ADDR_W-1:0] REG_END = {
      25'h30000, 25'h20000, 25'h18000, 25'h10000, 25'h0C000
   };

   localparam logic [ADDR_W-1:0] ROM_MAP_END = 25'h30000;

   // Decoder result for one stream address.
   typedef struct packed {
      logic             hit;
      logic [NREG-1:0]  sel;
      logic [OFF_W-1:0] off;
   } dec_t;

endpackage

// File: rtl/rom_region_dec.sv
// Combinational region decoder: stream address -> {hit, one-hot select, region offset}.
module rom_region_dec
   import solomon_rom_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   output dec_t              dec_c
);

   logic [NREG-1:0][ADDR_W-1:0] rel_c;
   logic [NREG-1:0]             sel_c;
   logic [OFF_W-1:0]            off_c;

   // One range check per region; below-base addresses wrap to large values and fail.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      assign rel_c[gi] = addr - REG_BASE[gi];
      assign sel_c[gi] = rel_c[gi] < ADDR_W'(REG_END[gi] - REG_BASE[gi]);
   end

   // Pick the offset of the (single) matching region.
   always_comb begin
      off_c = '0;
      for (int i = 0; i < NREG; i++) begin
         if (sel_c[i]) off_c = rel_c[i][OFF_W-1:0];
      end
   end

   // Pack the decode result.
   always_comb begin
      dec_c     = '0;
      dec_c.hit = |sel_c;
      dec_c.sel = sel_c;
      dec_c.off = off_c;
   end

endmodule

// File: rtl/rom_load_sched.sv
// ROM download sequencer: region writes, core reset hold, completion/error/checksum.
module rom_load_sched #(
   parameter int unsigned HOLD_CYC = 1024,
   parameter int unsigned NREG     = solomon_rom_pkg::NREG
) (
   input  logic            MCLK,
   input  logic            RESET,
   input  logic            DL,
   input  logic [24:0]     ROMAD,
   input  logic [7:0]      ROMDT,
   input  logic            ROMEN,
   output logic [NREG-1:0] WR_SEL,
   output logic [15:0]     WR_AD,
   output logic [7:0]      WR_DT,
   output logic            CORE_RST,
   output logic            DONE,
   output logic            ERR,
   output logic [15:0]     CKSUM
);

   localparam int unsigned      CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_RUN  = 2'd3;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic             dl_q;
   logic [CNT_W-1:0] cnt_q;
   logic [24:0]      last_q;

   logic             dl_rise_c;
   logic             dl_fall_c;
   logic             sess_start_c;
   logic             wr_en_c;
   logic             non_asc_c;

   solomon_rom_pkg::dec_t dec_c;

   rom_region_dec u_dec (
      .addr  (ROMAD),
      .dec_c (dec_c)
   );

   assign dl_rise_c    = DL & ~dl_q;
   assign dl_fall_c    = ~DL & dl_q;
   assign sess_start_c = dl_rise_c & (state_q != ST_LOAD);
   assign wr_en_c      = ROMEN & (state_q == ST_LOAD);
   assign non_asc_c    = (last_q != '1) & (ROMAD <= last_q);

   // State and DL edge-detect registers.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         dl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dl_q    <= DL;
      end
   end

   // Next-state logic; a new session always wins over the hold timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (dl_rise_c) state_d = ST_LOAD;
         ST_LOAD: if (dl_fall_c) state_d = ST_HOLD;
         ST_HOLD: begin
            if (dl_rise_c)               state_d = ST_LOAD;
            else if (cnt_q == CNT_LAST)  state_d = ST_RUN;
         end
         ST_RUN:  if (dl_rise_c) state_d = ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   // Settle counter, only runs while holding.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else if ((state_q != ST_HOLD) || dl_rise_c) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Write strobes, session bookkeeping and status outputs.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         WR_SEL   <= '0;
         WR_AD    <= '0;
         WR_DT    <= '0;
         CKSUM    <= '0;
         ERR      <= 1'b0;
         DONE     <= 1'b0;
         CORE_RST <= 1'b1;
         last_q   <= '1;
      end else begin
         WR_SEL <= '0;
         if (sess_start_c) begin
            CKSUM  <= '0;
            ERR    <= 1'b0;
            last_q <= '1;
         end else if (wr_en_c) begin
            last_q <= ROMAD;
            if (dec_c.hit) begin
               WR_SEL <= NREG'(dec_c.sel);
               WR_AD  <= dec_c.off;
               WR_DT  <= ROMDT;
               CKSUM  <= CKSUM + 16'(ROMDT);
            end
            if (!dec_c.hit || non_asc_c) ERR <= 1'b1;
         end
         CORE_RST <= ~((state_q == ST_RUN) & ~dl_rise_c);
         DONE     <= (state_q == ST_RUN) & ~dl_rise_c & ~ERR;
      end
   end

endmodule

// File: tb/tb_rom_load_sched.sv
// Randomized bench for rom_load_sched against a session-level reference model.
module tb_rom_load_sched;

   localparam int unsigned HOLD = 1024;
   localparam int unsigned NR   = 5;

   logic          MCLK  = 1'b0;
   logic          RESET = 1'b1;
   logic          DL    = 1'b0;
   logic [24:0]   ROMAD = '0;
   logic [7:0]    ROMDT = '0;
   logic          ROMEN = 1'b0;
   logic [NR-1:0] WR_SEL;
   logic [15:0]   WR_AD;
   logic [7:0]    WR_DT;
   logic          CORE_RST;
   logic          DONE;
   logic          ERR;
   logic [15:0]   CKSUM;

   int total = 0;
   int bad   = 0;

   rom_load_sched #(.HOLD_CYC(HOLD), .NREG(NR)) dut (
      .MCLK     (MCLK),
      .RESET    (RESET),
      .DL       (DL),
      .ROMAD    (ROMAD),
      .ROMDT    (ROMDT),
      .ROMEN    (ROMEN),
      .WR_SEL   (WR_SEL),
      .WR_AD    (WR_AD),
      .WR_DT    (WR_DT),
      .CORE_RST (CORE_RST),
      .DONE     (DONE),
      .ERR      (ERR),
      .CKSUM    (CKSUM)
   );

   always #5 MCLK = ~MCLK;

   // Reference map, written independently of the design package.
   int unsigned m_base [NR] = '{32'h00000, 32'h0C000, 32'h10000, 32'h18000, 32'h20000};
   int unsigned m_size [NR] = '{32'h0C000, 32'h04000, 32'h08000, 32'h08000, 32'h10000};

   // Session-level model state.
   bit          m_loading;
   bit          m_prev_dl;
   int          m_since;       // edges since the download ended, -1 when not settling
   bit          m_last_valid;
   int unsigned m_last;
   logic [NR-1:0] e_sel;
   logic [15:0] e_ad;
   logic [7:0]  e_dt;
   logic [15:0] e_ck;
   logic        e_err;
   logic        e_rst;
   logic        e_done;

   // Advance the model on each edge, then compare every output shortly after.
   always @(posedge MCLK) begin : p_model
      bit rise;
      bit fall;
      int r;
      if (RESET) begin
         m_loading = 0; m_prev_dl = 0; m_since = -1; m_last_valid = 0; m_last = 0;
         e_sel = '0; e_ad = '0; e_dt = '0; e_ck = '0; e_err = 0; e_rst = 1; e_done = 0;
      end else begin
         rise = DL && !m_prev_dl;
         fall = !DL && m_prev_dl;
         m_prev_dl = DL;
         e_sel = '0;
         if (m_loading && ROMEN) begin
            r = -1;
            for (int i = 0; i < int'(NR); i++)
               if (32'(ROMAD) >= m_base[i] && 32'(ROMAD) < m_base[i] + m_size[i]) r = i;
            if (m_last_valid && 32'(ROMAD) <= m_last) e_err = 1;
            if (r < 0) begin
               e_err = 1;
            end else begin
               e_sel = NR'(1 << r);
               e_ad  = 16'(32'(ROMAD) - m_base[r]);
               e_dt  = ROMDT;
               e_ck  = 16'(e_ck + 16'(ROMDT));
            end
            m_last = 32'(ROMAD);
            m_last_valid = 1;
         end
         if (rise) begin
            m_loading = 1; m_since = -1; e_ck = '0; e_err = 0; m_last_valid = 0;
         end else if (fall && m_loading) begin
            m_loading = 0; m_since = 0;
         end else if (m_since >= 0 && m_since <= int'(HOLD)) begin
            m_since++;
         end
         e_rst  = !(m_since > int'(HOLD));
         e_done = !e_rst && !e_err;
      end
      #1;
      total++;
      if (WR_SEL !== e_sel || WR_AD !== e_ad || WR_DT !== e_dt || CORE_RST !== e_rst ||
          DONE !== e_done || ERR !== e_err || CKSUM !== e_ck) begin
         bad++;
         $display("FAIL cycle t=%0t got sel=%b ad=%h dt=%h rst=%b done=%b err=%b ck=%h want sel=%b ad=%h dt=%h rst=%b done=%b err=%b ck=%h",
                  $time, WR_SEL, WR_AD, WR_DT, CORE_RST, DONE, ERR, CKSUM,
                  e_sel, e_ad, e_dt, e_rst, e_done, e_err, e_ck);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // One input cycle, driven on the falling edge.
   task automatic tick(input logic dl, input logic en, input logic [24:0] ad, input logic [7:0] dt);
      @(negedge MCLK);
      DL = dl; ROMEN = en; ROMAD = ad; ROMDT = dt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(DL, 1'b0, ROMAD, ROMDT);
   endtask

   task automatic sample();
      @(posedge MCLK);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_core_rst"}, 32'(CORE_RST), 32'd1);
      chk({tag, "_wr_sel"},   32'(WR_SEL),   32'd0);
      chk({tag, "_wr_ad"},    32'(WR_AD),    32'd0);
      chk({tag, "_wr_dt"},    32'(WR_DT),    32'd0);
      chk({tag, "_done"},     32'(DONE),     32'd0);
      chk({tag, "_err"},      32'(ERR),      32'd0);
      chk({tag, "_cksum"},    32'(CKSUM),    32'd0);
   endtask

   // After the fall edge has been sampled: check the reset release lands exactly on time.
   task automatic chk_release(input string tag, input logic [31:0] exp_done);
      repeat (HOLD) @(posedge MCLK);
      #2;
      chk({tag, "_rst_still_high"}, 32'(CORE_RST), 32'd1);
      sample();
      chk({tag, "_rst_low"}, 32'(CORE_RST), 32'd0);
      chk({tag, "_done"}, 32'(DONE), exp_done);
   endtask

   initial begin : p_main
      logic [24:0] cur;
      int n;
      sample();
      chk_reset_vals("reset");
      idle(2);
      @(negedge MCLK); RESET = 1'b0;
      idle(6);
      sample();
      chk("idle_hold_core", 32'(CORE_RST), 32'd1);

      // Strided full-map stream, data = address low byte.
      tick(1, 0, '0, '0);
      for (int a = 0; a < 32'h30000; a += 16) begin
         tick(1, 1, 25'(a), 8'(a));
         if (a == 32'h10000) begin
            sample();
            chk("r2_first_sel", 32'(WR_SEL), 32'b00100);
            chk("r2_first_ad",  32'(WR_AD),  32'h0000);
         end
      end
      tick(0, 0, '0, '0);
      sample();
      chk("stream_cksum", 32'(CKSUM), 32'h8000);
      chk("stream_err",   32'(ERR),   32'd0);
      chk_release("stream", 32'd1);

      // Single byte into the sound region, then an out-of-map byte.
      tick(1, 0, '0, '0);
      tick(1, 1, 25'h0C000, 8'hA5);
      sample();
      chk("snd_sel",   32'(WR_SEL), 32'b00010);
      chk("snd_ad",    32'(WR_AD),  32'h0000);
      chk("snd_dt",    32'(WR_DT),  32'hA5);
      chk("snd_cksum", 32'(CKSUM),  32'h00A5);
      tick(1, 1, 25'h30000, 8'h5A);
      sample();
      chk("miss_sel",   32'(WR_SEL), 32'd0);
      chk("miss_err",   32'(ERR),    32'd1);
      chk("miss_cksum", 32'(CKSUM),  32'h00A5);
      chk("miss_dt",    32'(WR_DT),  32'hA5);
      tick(0, 0, '0, '0);
      sample();
      chk_release("miss", 32'd0);

      // Descending pair: both written, error flagged.
      tick(1, 0, '0, '0);
      tick(1, 1, 25'h00100, 8'h11);
      sample();
      chk("asc_sel", 32'(WR_SEL), 32'b00001);
      chk("asc_ad",  32'(WR_AD),  32'h0100);
      chk("asc_err", 32'(ERR),    32'd0);
      tick(1, 1, 25'h000FF, 8'h22);
      sample();
      chk("desc_sel", 32'(WR_SEL), 32'b00001);
      chk("desc_ad",  32'(WR_AD),  32'h00FF);
      chk("desc_err", 32'(ERR),    32'd1);
      chk("desc_ck",  32'(CKSUM),  32'h0033);
      tick(0, 0, '0, '0);
      idle(HOLD + 4);

      // Restart at hold count 500; full hold must follow the second fall.
      tick(1, 0, '0, '0);
      tick(1, 1, 25'h20010, 8'h01);
      tick(0, 0, '0, '0);
      idle(500);
      tick(1, 0, '0, '0);
      sample();
      chk("restart_core_rst", 32'(CORE_RST), 32'd1);
      tick(1, 1, 25'h18004, 8'h40);
      tick(0, 0, '0, '0);
      sample();
      chk("restart_cksum", 32'(CKSUM), 32'h0040);
      chk_release("restart", 32'd1);

      // Reset pulse in the middle of a load.
      tick(1, 0, '0, '0);
      for (int i = 0; i < 5; i++) tick(1, 1, 25'(32'h100 * (i + 1)), 8'($urandom));
      @(posedge MCLK);
      #3 RESET = 1'b1;
      #1 chk_reset_vals("midload_rst");
      tick(0, 0, '0, '0);
      idle(3);
      @(negedge MCLK); RESET = 1'b0;
      idle(10);
      sample();
      chk("post_rst_idle", 32'(CORE_RST), 32'd1);
      tick(1, 0, '0, '0);
      tick(1, 1, 25'h00010, 8'h33);
      sample();
      chk("post_rst_cksum", 32'(CKSUM), 32'h0033);
      tick(0, 0, '0, '0);
      idle(HOLD + 3);

      // Randomized sessions with out-of-map, non-ascending and stray strobes.
      for (int s = 0; s < 8; s++) begin
         tick(1, 1'($urandom), 25'($urandom_range(0, 32'h2FFFF)), 8'($urandom));
         n   = $urandom_range(20, 80);
         cur = 25'($urandom_range(0, 32'h2F000));
         for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 19))
               0:       cur = 25'(32'h30000 + $urandom_range(0, 255));
               1:       if (cur > 25'd16) cur = cur - 25'($urandom_range(1, 16));
               default: cur = cur + 25'($urandom_range(1, 300));
            endcase
            tick(1, 1'($urandom_range(0, 3) != 0), cur, 8'($urandom));
         end
         tick(0, 1'($urandom), cur + 25'd1, 8'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(0, HOLD - 1);
         end else begin
            n = HOLD + $urandom_range(2, 20);
         end
         for (int j = 0; j < n; j++)
            tick(0, 1'($urandom), 25'($urandom_range(0, 32'h2FFFF)), 8'($urandom));
      end
      idle(HOLD + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin : p_watchdog
      #3_000_000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
